// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: MMIO UART controller with TX/RX FIFOs; CTRL register and irq enabled by UART_MMIO_IRQ_EN
module uart_mmio_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_addr,
  input  logic        mem_wr_en,
  input  logic        mem_rd_en,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_ready,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] tx_mem_q [FIFO_DEPTH];
  logic [7:0] rx_mem_q [FIFO_DEPTH];
  logic [AW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [7:0] tx_data_q, tx_data_d, tx_head, rx_head;
  logic [15:0] rdata_q, rdata_d, rd_val, status, ctrl_rd;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_idle;
  logic data_wr, data_rd, stat_wr, tx_push, tx_pop, rx_push, rx_pop;

  assign tx_empty = tx_wptr_q == tx_rptr_q;
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) && (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign rx_empty = rx_wptr_q == rx_rptr_q;
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) && (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign tx_head  = tx_mem_q[tx_rptr_q[AW-1:0]];
  assign rx_head  = rx_mem_q[rx_rptr_q[AW-1:0]];
  assign tx_idle  = tx_empty && state_q == IDLE && !tx_busy;
  assign data_wr  = mem_wr_en && mem_addr == 2'd0;
  assign data_rd  = mem_rd_en && mem_addr == 2'd0;
  assign stat_wr  = mem_wr_en && mem_addr == 2'd1;
  assign tx_pop   = state_q == LOAD;
  assign tx_push  = data_wr && (!tx_full || tx_pop);
  assign rx_pop   = data_rd && !rx_empty;
  assign rx_push  = rx_data_ready && (!rx_full || rx_pop);
  assign status   = {9'd0, rx_ovf_q, tx_ovf_q, tx_idle, rx_full, rx_empty, tx_full, tx_empty};
  assign tx_start = state_q == LOAD;
  assign tx_data  = tx_data_q;
  assign mem_rdata = rdata_q;

  // TX sequencer: hand one byte to uart_tx, then follow its busy handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = (!tx_empty && !tx_busy) ? LOAD : IDLE;
      LOAD:      state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_d = tx_busy ? WAIT_DONE : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FIFO pointers, sticky overflow flags, latched TX byte and registered read data
  always_comb begin
    tx_wptr_d = tx_wptr_q + (AW+1)'(tx_push);
    tx_rptr_d = tx_rptr_q + (AW+1)'(tx_pop);
    rx_wptr_d = rx_wptr_q + (AW+1)'(rx_push);
    rx_rptr_d = rx_rptr_q + (AW+1)'(rx_pop);
    tx_ovf_d  = (tx_ovf_q && !(stat_wr && mem_wdata[5])) || (data_wr && tx_full && !tx_pop);
    rx_ovf_d  = (rx_ovf_q && !(stat_wr && mem_wdata[6])) || (rx_data_ready && rx_full && !rx_pop);
    tx_data_d = state_d == LOAD ? tx_head : tx_data_q;
    rd_val    = mem_addr == 2'd0 ? (rx_empty ? 16'd0 : {1'b1, 7'd0, rx_head}) :
                mem_addr == 2'd1 ? status :
                mem_addr == 2'd2 ? ctrl_rd : 16'd0;
    rdata_d   = mem_rd_en ? rd_val : rdata_q;
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      tx_data_q <= 8'd0;
      rdata_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_data_q <= tx_data_d;
      rdata_q   <= rdata_d;
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= mem_wdata[7:0];
    if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_data;
  end

`ifdef UART_MMIO_IRQ_EN
  logic [1:0] ctrl_q, ctrl_d;
  logic irq_q, irq_d;
  logic unused_wdata;
  assign unused_wdata = ^{mem_wdata[15:8], mem_wdata[4:2]};
  assign ctrl_rd = {14'd0, ctrl_q};
  assign irq = irq_q;

  // CTRL bit0 enables RX-data interrupt, bit1 enables TX-idle interrupt
  always_comb begin
    ctrl_d = (mem_wr_en && mem_addr == 2'd2) ? mem_wdata[1:0] : ctrl_q;
    irq_d  = (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_idle);
  end

  // CTRL and registered interrupt level
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= 2'd0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^{mem_wdata[15:8], mem_wdata[4:0]};
  assign ctrl_rd = 16'd0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl: scoreboard bench for uart_mmio_ctrl (build with or without UART_MMIO_IRQ_EN)
module tb_uart_mmio_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] mem_addr;
  logic mem_wr_en, mem_rd_en;
  logic [15:0] mem_wdata, mem_rdata;
  logic [7:0] tx_data;
  logic tx_start, tx_busy;
  logic [7:0] rx_data;
  logic rx_data_ready, irq;

  int checks = 0;
  int errors = 0;
  int tx_pulses = 0;
  int busy_cnt = 0;
  logic busy_hold = 1'b0;
  logic rd_d = 1'b0;
  logic [15:0] rd_exp[$];
  logic [7:0] tx_exp[$];

  always #5 clk = ~clk;

  uart_mmio_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_data_ready(rx_data_ready), .irq(irq)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    mem_addr = a; mem_wdata = d; mem_wr_en = 1'b1;
    @(negedge clk);
    mem_wr_en = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [15:0] exp);
    mem_addr = a; mem_rd_en = 1'b1;
    rd_exp.push_back(exp);
    @(negedge clk);
    mem_rd_en = 1'b0;
  endtask

  task automatic wr_rd(input logic [1:0] a, input logic [15:0] d, input logic [15:0] exp);
    mem_addr = a; mem_wdata = d; mem_wr_en = 1'b1; mem_rd_en = 1'b1;
    rd_exp.push_back(exp);
    @(negedge clk);
    mem_wr_en = 1'b0; mem_rd_en = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_data_ready = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
  endtask

  task automatic rx_rd(input logic [7:0] b, input logic [15:0] exp);
    rx_data = b; rx_data_ready = 1'b1;
    mem_addr = 2'd0; mem_rd_en = 1'b1;
    rd_exp.push_back(exp);
    @(negedge clk);
    rx_data_ready = 1'b0; mem_rd_en = 1'b0;
  endtask

  always @(posedge clk) rd_d <= mem_rd_en;

  // uart_tx stand-in: busy for 10 cycles after each start, or held by the bench
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) busy_cnt = 10;
      tx_busy = busy_hold || busy_cnt > 0;
      if (busy_cnt > 0) busy_cnt--;
    end
  end

  // monitor: pops the scoreboard whenever the DUT starts a byte or returns read data
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_pulses++;
        if (tx_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %h expected none", tx_data);
        end else check("tx_data", 16'(tx_data), 16'(tx_exp.pop_front()));
      end
      if (rd_d) begin
        if (rd_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got %h expected none", mem_rdata);
        end else check("rdata", mem_rdata, rd_exp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_addr = 2'd0; mem_wr_en = 1'b0; mem_rd_en = 1'b0; mem_wdata = 16'd0;
    rx_data = 8'd0; rx_data_ready = 1'b0;
    cyc(2);
    check("rst_rdata", mem_rdata, 16'd0);
    check("rst_tx_start", 16'(tx_start), 16'd0);
    check("rst_tx_data", 16'(tx_data), 16'd0);
    check("rst_irq", 16'(irq), 16'd0);
    rst = 1'b0;
    rd_reg(2'd1, 16'h0015);
    // single byte with start latency
    tx_exp.push_back(8'h68);
    wr_reg(2'd0, 16'h0068);
    check("tx_start_early", 16'(tx_start), 16'd0);
    cyc(1);
    check("tx_start_pulse", 16'(tx_start), 16'd1);
    cyc(1);
    check("tx_start_one_cycle", 16'(tx_start), 16'd0);
    cyc(15);
    rd_reg(2'd1, 16'h0015);
    check("tx_pulse_count1", 16'(tx_pulses), 16'd1);
    // TX overflow while uart_tx is held busy
    busy_hold = 1'b1;
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) tx_exp.push_back(8'(8'h41 + i));
      wr_reg(2'd0, 16'(16'h0041 + i));
    end
    rd_reg(2'd1, 16'h0026);
    busy_hold = 1'b0;
    cyc(150);
    check("tx_drained", 16'(tx_exp.size()), 16'd0);
    rd_reg(2'd1, 16'h0035);
    wr_reg(2'd1, 16'h0020);
    rd_reg(2'd1, 16'h0015);
    // RX path
    rx_push(8'h74);
    rx_push(8'h65);
    rd_reg(2'd0, 16'h8074);
    rd_reg(2'd0, 16'h8065);
    rd_reg(2'd0, 16'h0000);
    rd_reg(2'd1, 16'h0015);
    // RX full, simultaneous push+pop, then overrun
    for (int i = 0; i < 8; i++) rx_push(8'(8'h10 + i));
    rd_reg(2'd1, 16'h0019);
    rx_rd(8'h18, 16'h8010);
    rd_reg(2'd1, 16'h0019);
    rx_push(8'h19);
    rd_reg(2'd1, 16'h0059);
    for (int i = 1; i < 9; i++) rd_reg(2'd0, 16'(16'h8010 + i));
    rd_reg(2'd0, 16'h0000);
    wr_rd(2'd1, 16'h0040, 16'h0055);
    rd_reg(2'd1, 16'h0015);
    // reserved address
    wr_reg(2'd3, 16'hFFFF);
    rd_reg(2'd3, 16'h0000);
`ifdef UART_MMIO_IRQ_EN
    wr_reg(2'd2, 16'h0001);
    rd_reg(2'd2, 16'h0001);
    check("irq_idle", 16'(irq), 16'd0);
    rx_push(8'h33);
    cyc(1);
    check("irq_set", 16'(irq), 16'd1);
    rd_reg(2'd0, 16'h8033);
    cyc(1);
    check("irq_clear", 16'(irq), 16'd0);
`else
    wr_reg(2'd2, 16'h0003);
    rd_reg(2'd2, 16'h0000);
    rx_push(8'h33);
    cyc(2);
    check("irq_tied", 16'(irq), 16'd0);
    rd_reg(2'd0, 16'h8033);
`endif
    cyc(3);
    check("rd_queue_empty", 16'(rd_exp.size()), 16'd0);
    check("tx_queue_empty", 16'(tx_exp.size()), 16'd0);
    check("tx_pulse_total", 16'(tx_pulses), 16'd9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
